// File: rtl/beagleg_pkg.sv
// ---------------------------------------------------------------------------
// beagleg_pkg
//   Shared definitions for the BeagleG motion path: the 4-byte segment
//   record layout (byte offsets and bit-field slices), the segment stepper
//   FSM state encoding, the SPI front-end command codes, and a helper that
//   clamps a zero half-period to one tick.
// ---------------------------------------------------------------------------
package beagleg_pkg;

  // Words per motion record; the record layout below assumes exactly four.
  localparam int RECORD_WORDS = 4;

  // Byte offsets inside a record (little-endian 16-bit count).
  localparam int REC_MASK_BYTE     = 0;
  localparam int REC_DIR_BYTE      = 0;
  localparam int REC_COUNT_LO_BYTE = 1;
  localparam int REC_COUNT_HI_BYTE = 2;
  localparam int REC_PERIOD_BYTE   = 3;

  // Bit-field slices inside byte 0.
  localparam int REC_MASK_LSB   = 0;
  localparam int REC_DIR_LSB    = 4;
  localparam int REC_FIELD_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_LOAD    = 3'd3,
    ST_RUN_HI  = 3'd4,
    ST_RUN_LO  = 3'd5,
    ST_DONE    = 3'd6
  } stepper_state_t;

  // Commands decoded by the SPI front-end that fills the segment FIFO.
  typedef enum logic [7:0] {
    SPI_CMD_NOP           = 8'h00,
    SPI_CMD_WRITE_SEGMENT = 8'h01,
    SPI_CMD_READ_STATUS   = 8'h02
  } spi_cmd_t;

  // A half-period of 0 ticks would never end a phase; run it as 1 tick.
  function automatic logic [7:0] period_clamp(input logic [7:0] period);
    return (period == 8'd0) ? 8'd1 : period;
  endfunction

endpackage

// File: rtl/segment_stepper_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Free-running PRESCALE_BITS-wide counter that emits a one-clk tick on the
//   last cycle of every 2^PRESCALE_BITS-clk period. i_clear restarts the
//   period so the first tick lands exactly 2^PRESCALE_BITS clks later.
//   With PRESCALE_BITS = 0 every clk is a tick.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   i_clear  in   synchronous restart of the tick period
//   o_tick   out  one-clk tick strobe
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESCALE_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  // Keep a 1-bit counter for PRESCALE_BITS = 0; its terminal value is then 0,
  // so it never leaves 0 and o_tick stays high.
  localparam int CNT_W = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << PRESCALE_BITS) - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/segment_stepper.sv
// ---------------------------------------------------------------------------
// segment_stepper
//   Pops 4-byte motion records from the segment FIFO, assembles them and
//   plays each one out as a burst of fixed-rate step pulses on up to
//   NUM_MOTORS axes with registered direction levels.
//   Record: byte0[3:0] step mask, byte0[7:4] dir, byte1/byte2 count
//   (little-endian), byte3 half-period in ticks (0 runs as 1).
//   One tick = 2^PRESCALE_BITS clks.
// Build option:
//   STEPPER_DWELL_EN  when defined, a record with mask 0 and count != 0 runs
//                     the full pulse timing with step held low (a dwell);
//                     otherwise such a record completes right after LOAD.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   fifo_empty    in   FIFO has no words
//   fifo_read_en  out  pop one word; fifo_data valid the following cycle
//   fifo_data     in   FIFO read data
//   step          out  step pulses, one bit per axis
//   dir           out  direction levels, one bit per axis
//   busy          out  high from FETCH entry until the segment completes
//   seg_done      out  one-cycle pulse per completed record
//   seg_count     out  completed-record counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module segment_stepper #(
  parameter int NUM_MOTORS    = 4,
  parameter int WORD_SIZE     = 8,
  parameter int RECORD_WORDS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [WORD_SIZE-1:0]  fifo_data,
  output logic [NUM_MOTORS-1:0] step,
  output logic [NUM_MOTORS-1:0] dir,
  output logic                  busy,
  output logic                  seg_done,
  output logic [7:0]            seg_count
);

  import beagleg_pkg::*;

  localparam int IDX_W = $clog2(RECORD_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_WORDS - 1);

  stepper_state_t r_state;
  stepper_state_t w_state_next;

  logic [WORD_SIZE-1:0]  r_rec [RECORD_WORDS];
  logic [IDX_W-1:0]      r_idx;
  logic [15:0]           r_step_cnt;
  logic [7:0]            r_phase;
  logic [NUM_MOTORS-1:0] r_step;
  logic [NUM_MOTORS-1:0] r_dir;
  logic [7:0]            r_seg_count;

  logic [NUM_MOTORS-1:0] w_mask;
  logic [NUM_MOTORS-1:0] w_dir_bits;
  logic [15:0]           w_count;
  logic [7:0]            w_period;
  logic                  w_tick;
  logic                  w_phase_end;

  // Record fields decoded straight from the assembled bytes. The bytes are
  // only rewritten in CAPTURE, so they stay stable for the whole run and
  // also serve as the half-period reload value.
  assign w_mask     = r_rec[REC_MASK_BYTE][REC_MASK_LSB +: NUM_MOTORS];
  assign w_dir_bits = r_rec[REC_DIR_BYTE][REC_DIR_LSB +: NUM_MOTORS];
  assign w_count    = {r_rec[REC_COUNT_HI_BYTE][7:0], r_rec[REC_COUNT_LO_BYTE][7:0]};
  assign w_period   = period_clamp(r_rec[REC_PERIOD_BYTE][7:0]);

  // Last tick of the current half-period.
  assign w_phase_end = w_tick && (r_phase == 8'd1);

  tick_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == ST_LOAD),
    .o_tick  (w_tick)
  );

  // Next-state and FIFO handshake.
  always_comb begin
    w_state_next = r_state;
    fifo_read_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // An empty FIFO mid-record simply stalls here.
        if (!fifo_empty) begin
          fifo_read_en = 1'b1;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_state_next = (r_idx == LAST_IDX) ? ST_LOAD : ST_FETCH;
      end
      ST_LOAD: begin
        if (w_count == 16'd0) begin
          w_state_next = ST_DONE;
        end else if (w_mask == '0) begin
`ifdef STEPPER_DWELL_EN
          w_state_next = ST_RUN_HI;
`else
          w_state_next = ST_DONE;
`endif
        end else begin
          w_state_next = ST_RUN_HI;
        end
      end
      ST_RUN_HI: begin
        if (w_phase_end) begin
          w_state_next = ST_RUN_LO;
        end
      end
      ST_RUN_LO: begin
        if (w_phase_end) begin
          w_state_next = (r_step_cnt == 16'd1) ? ST_DONE : ST_RUN_HI;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_step_cnt  <= '0;
      r_phase     <= '0;
      r_step      <= '0;
      r_dir       <= '0;
      r_seg_count <= '0;
    end else begin
      r_state <= w_state_next;
      // step follows RUN_HI one clk late: dir (loaded in LOAD) therefore
      // settles one clk before the first rising step edge, and the pulse
      // width is unchanged.
      r_step  <= (r_state == ST_RUN_HI) ? w_mask : '0;
      case (r_state)
        ST_CAPTURE: begin
          r_rec[r_idx] <= fifo_data;
          r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
        ST_LOAD: begin
          r_dir      <= w_dir_bits;
          r_step_cnt <= w_count;
          r_phase    <= w_period;
        end
        ST_RUN_HI: begin
          if (w_tick) begin
            r_phase <= (r_phase == 8'd1) ? w_period : r_phase - 8'd1;
          end
        end
        ST_RUN_LO: begin
          if (w_tick) begin
            if (r_phase == 8'd1) begin
              r_phase    <= w_period;
              r_step_cnt <= r_step_cnt - 16'd1;
            end else begin
              r_phase <= r_phase - 8'd1;
            end
          end
        end
        ST_DONE: begin
          r_seg_count <= r_seg_count + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign step      = r_step;
  assign dir       = r_dir;
  assign busy      = (r_state != ST_IDLE);
  assign seg_done  = (r_state == ST_DONE);
  assign seg_count = r_seg_count;

endmodule

// File: tb/tb_segment_stepper.sv
// ---------------------------------------------------------------------------
// tb_segment_stepper
//   Two instances share one FIFO model: dut0 (PRESCALE_BITS=0) runs most
//   records, dut4 (PRESCALE_BITS=4) runs the prescaled record. `sel` picks
//   which instance sees the FIFO; the other sees it as empty.
//   Stimulus pushes hand-computed expectations into sb_q; a monitor measures
//   each segment and compares at every seg_done pulse.
//   Latency = clks from the last pop (FETCH) cycle to the seg_done cycle.
// ---------------------------------------------------------------------------
module tb_segment_stepper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  // FIFO model
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty_m;
  assign fifo_empty_m = (wr_ptr == rd_ptr);

  logic       empty0, empty4, rd0, rd4, busy0, busy4, done0, done4;
  logic [3:0] step0, step4, dir0, dir4;
  logic [7:0] cnt0, cnt4;

  assign empty0 = sel | fifo_empty_m;
  assign empty4 = ~sel | fifo_empty_m;

  always @(posedge clk) begin
    if (sel ? rd4 : rd0) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  segment_stepper #(.NUM_MOTORS(4), .WORD_SIZE(8), .RECORD_WORDS(4), .PRESCALE_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_read_en(rd0), .fifo_data(fifo_data),
    .step(step0), .dir(dir0), .busy(busy0), .seg_done(done0), .seg_count(cnt0)
  );

  segment_stepper #(.NUM_MOTORS(4), .WORD_SIZE(8), .RECORD_WORDS(4), .PRESCALE_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(empty4), .fifo_read_en(rd4), .fifo_data(fifo_data),
    .step(step4), .dir(dir4), .busy(busy4), .seg_done(done4), .seg_count(cnt4)
  );

  // Signals of the instance currently under observation.
  logic       m_rd, m_empty, m_done;
  logic [3:0] m_step, m_dir;
  logic [7:0] m_cnt;
  assign m_rd    = sel ? rd4    : rd0;
  assign m_empty = sel ? empty4 : empty0;
  assign m_done  = sel ? done4  : done0;
  assign m_step  = sel ? step4  : step0;
  assign m_dir   = sel ? dir4   : dir0;
  assign m_cnt   = sel ? cnt4   : cnt0;

  typedef struct {
    int seg;
    int dir;
    int pulses;
    int mask;
    int high;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pop_err = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_rec(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    push_byte(b0);
    push_byte(b1);
    push_byte(b2);
    push_byte(b3);
  endtask

  task automatic push_exp(input int seg, input int d, input int pulses,
                          input int mask, input int high, input int lat);
    exp_t e;
    e.seg = seg; e.dir = d; e.pulses = pulses;
    e.mask = mask; e.high = high; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d segments outstanding, expected 0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  int         cyc = 0, last_pop = 0, pops = 0, pulses = 0;
  int         hi_len = 0, hi_min = 1 << 30, hi_max = 0, pend = -1;
  logic [3:0] mask_seen = 4'h0, prev_step = 4'h0, dir_rise = 4'h0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend >= 0) begin
        check("seg_count", int'(m_cnt), pend);
        pend = -1;
      end
      if (rst) begin
        pops = 0; pulses = 0; hi_len = 0; hi_min = 1 << 30; hi_max = 0;
        mask_seen = 4'h0; prev_step = 4'h0; dir_rise = 4'h0;
      end else begin
        if (m_rd) begin
          pops++;
          last_pop = cyc;
          if (m_empty) pop_err++;
        end
        if (m_step != 4'h0) begin
          mask_seen = mask_seen | m_step;
          hi_len++;
          if (prev_step == 4'h0) begin
            pulses++;
            if (pulses == 1) dir_rise = m_dir;
          end
        end else if (prev_step != 4'h0) begin
          if (hi_len < hi_min) hi_min = hi_len;
          if (hi_len > hi_max) hi_max = hi_len;
          hi_len = 0;
        end
        prev_step = m_step;
        if (m_done) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_seg_done: got seg_done with seg_count %0d, expected none", m_cnt);
          end else begin
            e = sb_q.pop_front();
            $display("seg_done: exp_seg=%0d dir=%0h pulses=%0d mask=%0h high=%0d..%0d pops=%0d latency=%0d",
                     e.seg, m_dir, pulses, mask_seen, hi_min, hi_max, pops, cyc - last_pop);
            check("dir", int'(m_dir), e.dir);
            check("pulses", pulses, e.pulses);
            check("mask", int'(mask_seen), e.mask);
            check("pops", pops, 4);
            check("latency", cyc - last_pop, e.lat);
            if (e.pulses > 0) begin
              check("high_min", hi_min, e.high);
              check("high_max", hi_max, e.high);
              check("dir_at_first_step", int'(dir_rise), e.dir);
            end
            pend = e.seg;
          end
          pops = 0; pulses = 0; hi_len = 0; hi_min = 1 << 30; hi_max = 0;
          mask_seen = 4'h0; prev_step = 4'h0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int stall_bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", int'(step0), 0);
    check("rst_dir", int'(dir0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_seg_done", int'(done0), 0);
    check("rst_seg_count", int'(cnt0), 0);
    check("rst_read_en", int'(rd0), 0);
    rst = 1'b0;

    // 1: reset while a segment is in RUN_HI
    push_rec(8'h51, 8'h03, 8'h00, 8'h02);
    n = 0;
    while (step0 == 4'h0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_step_seen", int'(step0 != 4'h0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t1_step_after_rst", int'(step0), 0);
    check("t1_busy_after_rst", int'(busy0), 0);
    check("t1_count_after_rst", int'(cnt0), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: mask 1, dir 5, 3 steps, half-period 2
    push_exp(1, 5, 3, 1, 2, 15);
    push_rec(8'h51, 8'h03, 8'h00, 8'h02);
    wait_drain("t2_drain", 200);
    check("t2_dir_hold", int'(dir0), 5);

    // 3: FIFO runs dry after byte1
    push_exp(2, 3, 2, 2, 1, 7);
    push_byte(8'h32);
    push_byte(8'h02);
    n = 0;
    while (rd_ptr != wr_ptr && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t3_first_bytes_popped", rd_ptr, wr_ptr);
    repeat (2) @(posedge clk);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd0 || !busy0 || step0 != 4'h0) stall_bad++;
    end
    check("t3_stall", stall_bad, 0);
    check("t3_busy", int'(busy0), 1);
    @(posedge clk);
    #1;
    push_byte(8'h00);
    push_byte(8'h01);
    wait_drain("t3_drain", 200);

    // 4 + 6 back to back: count 0, then mask 0 with count 2
    push_exp(3, 0, 0, 0, 0, 3);
`ifdef STEPPER_DWELL_EN
    push_exp(4, 0, 0, 0, 0, 15);
`else
    push_exp(4, 0, 0, 0, 0, 3);
`endif
    push_rec(8'h0F, 8'h00, 8'h00, 8'h05);
    push_rec(8'h00, 8'h02, 8'h00, 8'h03);
    wait_drain("t46_drain", 200);

    // 5: half-period 0, count 1, PRESCALE_BITS=4 instance
    sel = 1'b1;
    @(posedge clk);
    #1;
    push_exp(1, 1, 1, 1, 16, 35);
    push_rec(8'h11, 8'h01, 8'h00, 8'h00);
    wait_drain("t5_drain", 500);
    check("t5_busy_after", int'(busy4), 0);

    check("pop_while_empty", pop_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
